// File: rtl/frame_loader_sram.sv
// Frame loader for the 3x3 smoothing filter: writes one raster frame into the SRAM input
// region, hands the bus to the filter with a start pulse, then waits for its done pulse.
module frame_loader_sram #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int AW    = 19,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          sram_csn,
    output logic          sram_wen,
    output logic [AW-1:0] sram_ad,
    output logic [DW-1:0] sram_din,
    output logic          bus_own,
    output logic          filt_start,
    input  logic          filt_done,
    output logic [7:0]    frame_cnt,
    output logic          err_len
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_PIX = AW'(IMG_W * IMG_H - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] pix_cnt_q, pix_cnt_d;
    logic          s_ready_q, s_ready_d;
    logic          csn_q, csn_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] ad_q, ad_d;
    logic [DW-1:0] din_q, din_d;
    logic          bus_own_q, bus_own_d;
    logic          filt_start_q, filt_start_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          err_len_q, err_len_d;
    logic          accept_s;
    logic          final_s;

    // s_ready is a register, so the handshake never depends combinationally on s_valid
    assign accept_s = s_valid & s_ready_q & (state_q == ST_LOAD);
    assign final_s  = accept_s & (pix_cnt_q == LAST_PIX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  state_d = final_s ? ST_START : ST_LOAD;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  state_d = filt_done ? ST_LOAD : ST_WAIT;
            default:  state_d = ST_LOAD;
        endcase
    end

    // Output / datapath next values; an early s_last restarts the frame at address 0
    always_comb begin
        pix_cnt_d = pix_cnt_q;
        if (accept_s) begin
            if (final_s || s_last) begin
                pix_cnt_d = '0;
            end else begin
                pix_cnt_d = pix_cnt_q + AW'(1);
            end
        end else if ((state_q == ST_WAIT) && filt_done) begin
            pix_cnt_d = '0;
        end else begin
            pix_cnt_d = pix_cnt_q;
        end
        csn_d        = ~accept_s;
        wen_d        = accept_s;
        ad_d         = accept_s ? pix_cnt_q : ad_q;
        din_d        = accept_s ? s_data : din_q;
        err_len_d    = err_len_q | (accept_s & (s_last != final_s));
        frame_cnt_d  = final_s ? (frame_cnt_q + 8'd1) : frame_cnt_q;
        s_ready_d    = (state_d == ST_LOAD);
        bus_own_d    = (state_d != ST_WAIT);
        filt_start_d = (state_d == ST_START);
    end

    // Registered outputs and pixel counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q    <= '0;
            s_ready_q    <= 1'b0;
            csn_q        <= 1'b1;
            wen_q        <= 1'b0;
            ad_q         <= '0;
            din_q        <= '0;
            bus_own_q    <= 1'b1;
            filt_start_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            err_len_q    <= 1'b0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            s_ready_q    <= s_ready_d;
            csn_q        <= csn_d;
            wen_q        <= wen_d;
            ad_q         <= ad_d;
            din_q        <= din_d;
            bus_own_q    <= bus_own_d;
            filt_start_q <= filt_start_d;
            frame_cnt_q  <= frame_cnt_d;
            err_len_q    <= err_len_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign sram_csn   = csn_q;
    assign sram_wen   = wen_q;
    assign sram_ad    = ad_q;
    assign sram_din   = din_q;
    assign bus_own    = bus_own_q;
    assign filt_start = filt_start_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_len    = err_len_q;

endmodule

// File: tb/tb_frame_loader_sram.sv
// Scoreboard bench for frame_loader_sram on a reduced 8x4 frame.
module tb_frame_loader_sram;

    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int AW    = 19;
    localparam int DW    = 16;
    localparam int N     = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          sram_csn, sram_wen;
    logic [AW-1:0] sram_ad;
    logic [DW-1:0] sram_din;
    logic          bus_own, filt_start;
    logic          filt_done = 1'b0;
    logic [7:0]    frame_cnt;
    logic          err_len;

    frame_loader_sram #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_ad(sram_ad),
        .sram_din(sram_din), .bus_own(bus_own), .filt_start(filt_start),
        .filt_done(filt_done), .frame_cnt(frame_cnt), .err_len(err_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          e;
        logic [7:0]    f;
    } wr_t;

    wr_t           exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            start_cnt = 0;
    logic          prev_fs = 1'b0;
    logic [AW-1:0] m_cnt = '0;
    logic          m_err = 1'b0;
    logic [7:0]    m_frames = 8'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model of the loader's address/error/frame bookkeeping at each accepted pixel
    task automatic model_accept(input logic [DW-1:0] d, input logic last);
        wr_t w;
        w.a = m_cnt;
        w.d = d;
        if (m_cnt == AW'(N - 1)) begin
            if (!last) m_err = 1'b1;
            m_cnt = '0;
            m_frames = m_frames + 8'd1;
        end else if (last) begin
            m_err = 1'b1;
            m_cnt = '0;
        end else begin
            m_cnt = m_cnt + AW'(1);
        end
        w.e = m_err;
        w.f = m_frames;
        exp_q.push_back(w);
    endtask

    // Output monitor: every write must match the oldest expected entry
    always @(negedge clk) begin
        if (!sram_csn && sram_wen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {13'd0, sram_ad}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", {13'd0, sram_ad}, {13'd0, w.a});
                check("wr_data", {16'd0, sram_din}, {16'd0, w.d});
                check("wr_err", {31'd0, err_len}, {31'd0, w.e});
                check("wr_frame_cnt", {24'd0, frame_cnt}, {24'd0, w.f});
                check("wr_bus_own", {31'd0, bus_own}, 32'd1);
            end
        end
        if (filt_start) begin
            start_cnt++;
            check("start_width", {31'd0, prev_fs}, 32'd0);
            check("start_final_wr", {31'd0, ~sram_csn & sram_wen}, 32'd1);
            check("start_final_addr", {13'd0, sram_ad}, N - 1);
        end
        prev_fs = filt_start;
    end

    task automatic send_pix(input logic [DW-1:0] d, input logic last, input int gap);
        int guard;
        guard = 0;
        while ($urandom_range(99) < gap) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            model_accept(d, last);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int gap, input logic with_last);
        for (int i = 0; i < N; i++) begin
            send_pix(DW'(i), with_last && (i == N - 1), gap);
        end
    endtask

    // Wait for the start pulse, then confirm the bus is released in WAIT
    task automatic wait_start(input logic [7:0] exp_frames);
        int g;
        g = 0;
        while (!filt_start && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("start_seen", {31'd0, filt_start}, 32'd1);
        check("start_frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_frames});
        check("start_s_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        check("wait_bus_own", {31'd0, bus_own}, 32'd0);
        check("wait_csn", {31'd0, sram_csn}, 32'd1);
        check("wait_start_low", {31'd0, filt_start}, 32'd0);
        check("q_empty_frame", exp_q.size(), 32'd0);
    endtask

    task automatic done_pulse();
        filt_done = 1'b1;
        s_valid   = 1'b0;
        @(negedge clk);
        filt_done = 1'b0;
        check("done_s_ready", {31'd0, s_ready}, 32'd1);
        check("done_bus_own", {31'd0, bus_own}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_csn", {31'd0, sram_csn}, 32'd1);
        check("rst_wen", {31'd0, sram_wen}, 32'd0);
        check("rst_ad", {13'd0, sram_ad}, 32'd0);
        check("rst_din", {16'd0, sram_din}, 32'd0);
        check("rst_bus_own", {31'd0, bus_own}, 32'd1);
        check("rst_filt_start", {31'd0, filt_start}, 32'd0);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        check("rst_err_len", {31'd0, err_len}, 32'd0);
        check("q_empty_rst", exp_q.size(), 32'd0);
        exp_q.delete();
        m_cnt = '0;
        m_err = 1'b0;
        m_frames = 8'd0;
        @(negedge clk);
        check("rst_ready_after", {31'd0, s_ready}, 32'd1);
    endtask

    initial begin
        int starts0;
        @(negedge clk);
        do_reset();

        // Clean back-to-back frame
        send_frame(0, 1'b1);
        wait_start(8'd1);
        check("t1_err_len", {31'd0, err_len}, 32'd0);
        done_pulse();

        // Random idle gaps, then hold s_valid high during WAIT
        send_frame(30, 1'b1);
        wait_start(8'd2);
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("wait_hold_ready", {31'd0, s_ready}, 32'd0);
        end
        done_pulse();

        // Early s_last restarts the frame, then a clean frame follows
        for (int i = 0; i <= 10; i++) send_pix(DW'(16'h100 + i), i == 10, 0);
        check("t3_err_len", {31'd0, err_len}, 32'd1);
        send_frame(10, 1'b1);
        wait_start(8'd3);
        check("t3_err_sticky", {31'd0, err_len}, 32'd1);
        done_pulse();

        // Reset mid-frame, then a frame missing its s_last
        for (int i = 0; i < 20; i++) send_pix(DW'(16'h200 + i), 1'b0, 0);
        do_reset();
        send_frame(0, 1'b0);
        wait_start(8'd1);
        check("t5_missing_last_err", {31'd0, err_len}, 32'd1);
        done_pulse();

        // 257 frames wrap frame_cnt back to 1
        do_reset();
        starts0 = start_cnt;
        for (int f = 0; f < 257; f++) begin
            send_frame(0, 1'b1);
            wait_start(8'(f + 1));
            done_pulse();
        end
        check("t6_frame_cnt", {24'd0, frame_cnt}, 32'd1);
        check("t6_start_count", start_cnt - starts0, 32'd257);
        repeat (3) @(negedge clk);
        check("q_empty_end", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
